// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one fixed-latency CORDIC vectoring pipeline among NREQ requesters.
// Optional: define CORDIC_ARB_PRIO0_EN to give requester 0 strict priority over the rotating others.
module cordic_arbiter #(
  parameter int NREQ     = 4,
  parameter int PIPE_LAT = 24,
  parameter int XW       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*XW-1:0]      req_x,
  input  logic [NREQ*XW-1:0]      req_y,
  output logic                    core_ena,
  output logic [XW-1:0]           core_x,
  output logic [XW-1:0]           core_y,
  input  logic [15:0]             core_ao,
  input  logic [19:0]             core_ro,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [$clog2(NREQ)-1:0] res_id,
  output logic [15:0]             res_ang,
  output logic [19:0]             res_rad,
  input  logic                    flush_req,
  output logic                    flush_done,
  output logic                    busy,
  output logic [1:0]              fsm_state
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE, ST_HOLD} state_t;

  state_t               state, state_nxt;
  logic [IDW-1:0]       ptr, next_ptr;
  logic [IDW-1:0]       winner;
  logic                 grant_any;
  logic                 prio_hit;
  logic [NREQ-1:0]      rr_cand;
  logic [PIPE_LAT-1:0]  tag_vld;
  logic [IDW-1:0]       tag_id [PIPE_LAT];
  logic                 capture;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // req_ready never depends on anything but req_valid, state and the result stall;
  // res_valid holds its data until res_ready is seen high on an edge.
  assign core_ena  = !(res_valid && !res_ready);
  assign busy      = (|tag_vld) || res_valid;
  assign fsm_state = state;
  assign capture   = core_ena && tag_vld[PIPE_LAT-1];

  always_comb begin
    int idx;
    grant_any = 1'b0;
    winner    = '0;
    prio_hit  = 1'b0;
    rr_cand   = req_valid;
    idx       = 0;
`ifdef CORDIC_ARB_PRIO0_EN
    prio_hit   = req_valid[0];
    rr_cand[0] = 1'b0;
`endif
    if (prio_hit) begin
      grant_any = 1'b1;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(ptr) + k) % NREQ;
        if (!grant_any && rr_cand[idx]) begin
          grant_any = 1'b1;
          winner    = IDW'(idx);
        end
      end
    end
    if (!(core_ena && state == ST_RUN)) grant_any = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    core_x    = '0;
    core_y    = '0;
    next_ptr  = (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
    if (grant_any) begin
      req_ready[winner] = 1'b1;
      core_x            = req_x[int'(winner)*XW +: XW];
      core_y            = req_y[int'(winner)*XW +: XW];
    end
  end

  // Requester 0's priority grants leave the rotation untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_any && !prio_hit) begin
      ptr <= next_ptr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld <= '0;
      for (int k = 0; k < PIPE_LAT; k++) tag_id[k] <= '0;
    end else if (core_ena) begin
      tag_vld   <= {tag_vld[PIPE_LAT-2:0], grant_any};
      tag_id[0] <= winner;
      for (int k = 1; k < PIPE_LAT; k++) tag_id[k] <= tag_id[k-1];
    end
  end

  // Capture takes precedence over accept so back-to-back results leave no bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_id    <= '0;
      res_ang   <= '0;
      res_rad   <= '0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_id    <= tag_id[PIPE_LAT-1];
      res_ang   <= core_ao;
      res_rad   <= core_ro;
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // ST_HOLD is the "DONE with flush_done low" phase while flush_req stays high.
  always_comb begin
    state_nxt  = state;
    flush_done = 1'b0;
    case (state)
      ST_RUN:   if (flush_req) state_nxt = ST_DRAIN;
      ST_DRAIN: if (!(|tag_vld) && !res_valid) state_nxt = ST_DONE;
      ST_DONE: begin
        flush_done = 1'b1;
        state_nxt  = flush_req ? ST_HOLD : ST_RUN;
      end
      ST_HOLD:  if (!flush_req) state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed scoreboard bench for cordic_arbiter with a behavioural stand-in for the shared pipeline.
module tb_cordic_arbiter;
  localparam int NREQ     = 4;
  localparam int PIPE_LAT = 24;
  localparam int XW       = 16;
  localparam int IDW      = 2;
  localparam int EW       = IDW + 36;

  logic               clk, rst_n;
  logic [NREQ-1:0]    req_valid, req_ready;
  logic [NREQ*XW-1:0] req_x, req_y;
  logic               core_ena;
  logic [XW-1:0]      core_x, core_y;
  logic [15:0]        core_ao;
  logic [19:0]        core_ro;
  logic               res_valid, res_ready;
  logic [IDW-1:0]     res_id;
  logic [15:0]        res_ang;
  logic [19:0]        res_rad;
  logic               flush_req, flush_done, busy;
  logic [1:0]         fsm_state;

  logic [EW-1:0] exp_q[$];
  int n_chk = 0;
  int n_fail = 0;

  cordic_arbiter #(.NREQ(NREQ), .PIPE_LAT(PIPE_LAT), .XW(XW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .core_ena(core_ena), .core_x(core_x), .core_y(core_y),
    .core_ao(core_ao), .core_ro(core_ro), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_ang(res_ang), .res_rad(res_rad), .flush_req(flush_req),
    .flush_done(flush_done), .busy(busy), .fsm_state(fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in vectoring function: easy to hand-compute, distinct per operand pair.
  function automatic logic [15:0] m_ang(input logic [15:0] x, input logic [15:0] y);
    return x ^ {y[7:0], y[15:8]};
  endfunction
  function automatic logic [19:0] m_rad(input logic [15:0] x, input logic [15:0] y);
    return {4'h0, x} + {4'h0, y};
  endfunction

  // Shared pipeline model: no reset, advances only on core_ena.
  logic [15:0] pa [PIPE_LAT];
  logic [19:0] pr [PIPE_LAT];
  always @(posedge clk) begin
    if (core_ena) begin
      pa[0] <= m_ang(core_x, core_y);
      pr[0] <= m_rad(core_x, core_y);
      for (int k = 1; k < PIPE_LAT; k++) begin
        pa[k] <= pa[k-1];
        pr[k] <= pr[k-1];
      end
    end
  end
  assign core_ao = pa[PIPE_LAT-1];
  assign core_ro = pr[PIPE_LAT-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result: got id=%0d ang=%0h rad=%0h with empty queue", res_id, res_ang, res_rad);
      end else begin
        check("result", {26'h0, res_id, res_ang, res_rad}, {26'h0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int s);
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*XW +: XW] = {4'(i + 1), 12'(s * 7 + i)};
      req_y[i*XW +: XW] = {8'(s + 3 * i), 8'(s * 5)};
    end
  endtask

  // Drive one cycle of requests and check the expected grant (-1 means none).
  task automatic issue(input logic [NREQ-1:0] vmask, input int exp_w, input int s);
    logic [NREQ-1:0] exp_rdy;
    logic [15:0] x, y;
    step();
    req_valid = vmask;
    set_ops(s);
    @(negedge clk);
    exp_rdy = '0;
    if (exp_w >= 0) exp_rdy[exp_w] = 1'b1;
    check("req_ready", {60'h0, req_ready}, {60'h0, exp_rdy});
    if (exp_w >= 0) begin
      x = req_x[exp_w*XW +: XW];
      y = req_y[exp_w*XW +: XW];
      exp_q.push_back({IDW'(exp_w), m_ang(x, y), m_rad(x, y)});
    end
  endtask

  task automatic do_reset();
    step();
    rst_n = 1'b0;
    req_valid = '0;
    flush_req = 1'b0;
    res_ready = 1'b1;
    step();
    step();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) break;
    end
    check(name, {63'h0, (exp_q.size() == 0 && !busy)}, 64'h1);
  endtask

  task automatic wait_res(input string name);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (res_valid) begin
        found = 1'b1;
        break;
      end
    end
    check(name, {63'h0, found}, 64'h1);
  endtask

  // Expected winners with requester 0 always contending.
  function automatic int rr_exp(input int c, input int modulo, input int hi);
`ifdef CORDIC_ARB_PRIO0_EN
    return 0;
`else
    return (modulo == 2) ? ((c % 2 == 0) ? 0 : hi) : c % modulo;
`endif
  endfunction

  // ---------------- directed tests ----------------
  initial begin
    int lat, run, pulses, done_at, last_acc, cnt;
    rst_n = 1'b0;
    req_valid = '0;
    req_x = '0;
    req_y = '0;
    res_ready = 1'b1;
    flush_req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_res_valid", {63'h0, res_valid}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_res_data", {26'h0, res_id, res_ang, res_rad}, 64'h0);
    check("rst_flush_done", {63'h0, flush_done}, 64'h0);
    check("rst_core_ena", {63'h0, core_ena}, 64'h1);
    check("rst_state", {62'h0, fsm_state}, 64'h0);
    step();
    rst_n = 1'b1;

    // T1: single op from requester 2, result expected 25 cycles after the grant.
    step();
    req_valid = 4'b0100;
    req_x[2*XW +: XW] = 16'h4000;
    req_y[2*XW +: XW] = 16'h0000;
    @(negedge clk);
    check("t1_req_ready", {60'h0, req_ready}, 64'h4);
    exp_q.push_back({2'd2, 16'h4000, 20'h04000});
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      req_valid = '0;
      @(negedge clk);
      if (res_valid) begin
        lat = n;
        break;
      end
    end
    check("t1_latency", 64'(lat), 64'd25);
    drain("t1_drain");

    // T2: all four contend for 8 cycles; results return back-to-back.
    do_reset();
    for (int c = 0; c < 8; c++) issue(4'hF, rr_exp(c, 4, 0), c);
    step();
    req_valid = '0;
    wait_res("t2_result_seen");
    run = 0;
    while (res_valid && run < 20) begin
      run++;
      @(negedge clk);
    end
    check("t2_back_to_back", 64'(run), 64'd8);
    drain("t2_drain");

    // T3: three ops, consumer stalls for 5 cycles from the first result.
    do_reset();
    issue(4'b0001, 0, 20);
    issue(4'b0010, 1, 21);
    issue(4'b0100, 2, 22);
    step();
    req_valid = '0;
    res_ready = 1'b0;
    wait_res("t3_result_seen");
    check("t3_stall_ena", {63'h0, core_ena}, 64'h0);
    for (int s = 1; s < 5; s++) begin
      step();
      req_valid = 4'b1000;
      @(negedge clk);
      check("t3_stall_ena", {63'h0, core_ena}, 64'h0);
      check("t3_stall_ready", {60'h0, req_ready}, 64'h0);
      check("t3_stall_hold", {63'h0, res_valid}, 64'h1);
    end
    step();
    req_valid = '0;
    res_ready = 1'b1;
    @(negedge clk);
    check("t3_release_ena", {63'h0, core_ena}, 64'h1);
    drain("t3_drain");

    // T4: flush with three ops in flight; flush_done follows the last accept
    // by two cycles (one DRAIN cycle observing empty, then the DONE cycle).
    do_reset();
    issue(4'b0001, 0, 30);
    issue(4'b0010, 1, 31);
    issue(4'b0100, 2, 32);
    step();
    req_valid = '0;
    flush_req = 1'b1;
    step();
    req_valid = 4'hF;
    pulses = 0;
    done_at = -1;
    last_acc = -100;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      check("t4_no_grant", {60'h0, req_ready}, 64'h0);
      if (res_valid && res_ready) last_acc = n;
      if (flush_done) begin
        pulses++;
        done_at = n;
      end
      if (pulses > 0 && n >= done_at + 3) break;
      step();
    end
    check("t4_pulses", 64'(pulses), 64'd1);
    check("t4_done_timing", 64'(done_at), 64'(last_acc + 2));
    step();
    flush_req = 1'b0;
    @(negedge clk);
    check("t4_hold_no_grant", {60'h0, req_ready}, 64'h0);
`ifdef CORDIC_ARB_PRIO0_EN
    issue(4'hF, 0, 33);
`else
    issue(4'hF, 3, 33);
`endif
    step();
    req_valid = '0;
    drain("t4_drain");

    // T5: reset with 10 ops in flight; nothing stale may appear afterwards.
    do_reset();
    for (int c = 0; c < 10; c++) issue(4'hF, rr_exp(c, 4, 0), 40 + c);
    step();
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    check("t5_rst_busy", {63'h0, busy}, 64'h0);
    check("t5_rst_res_valid", {63'h0, res_valid}, 64'h0);
    step();
    step();
    exp_q.delete();
    rst_n = 1'b1;
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (res_valid) cnt++;
    end
    check("t5_no_stale", 64'(cnt), 64'd0);
    check("t5_idle_busy", {63'h0, busy}, 64'h0);

    // T6: requesters 0 and 3 contend for 4 cycles.
    do_reset();
    for (int c = 0; c < 4; c++) issue(4'b1001, rr_exp(c, 2, 3), 60 + c);
    step();
    req_valid = '0;
    drain("t6_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
